// File: rtl/seg_scan_ctrl.sv
// Eight-digit (configurable) seven-segment scanner with frame-aligned, tear-free value commit.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  output logic                    pending_o,
  output logic [3:0]              num_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     r_tick;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_shadow;
  logic [VAL_W-1:0]      r_disp;
  logic                  r_pending;
  logic [3:0]            r_num;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  logic                  w_adv;
  logic                  w_wrap;
  logic [TICK_W-1:0]     w_tick_next;
  logic [IDX_W-1:0]      w_idx_next;
  logic [VAL_W-1:0]      w_shadow_next;
  logic [VAL_W-1:0]      w_disp_next;
  logic                  w_pending_next;
  logic [3:0]            w_num_next;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [NUM_DIGITS-1:0] w_blank;

  // Slot timing, digit walk, and frame-boundary commit of the captured value
  always_comb begin
    w_adv          = (r_tick == TICK_LAST);
    w_wrap         = w_adv && (r_idx == IDX_LAST);
    w_tick_next    = w_adv ? '0 : r_tick + TICK_W'(1);
    w_idx_next     = r_idx;
    w_shadow_next  = r_shadow;
    w_disp_next    = r_disp;
    w_pending_next = r_pending;

    if (w_adv) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    if (load_i) begin
      w_shadow_next = value_i;
    end

    if (w_wrap) begin
      // A load landing on the boundary bypasses the shadow and shows immediately
      if (load_i) begin
        w_disp_next = value_i;
      end else if (r_pending) begin
        w_disp_next = r_shadow;
      end
      w_pending_next = 1'b0;
    end else if (load_i) begin
      w_pending_next = 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_zero_upper;

  // Digit k>0 is dark when it and every more significant nibble are zero
  always_comb begin
    w_zero_upper = 1'b1;
    w_blank      = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      w_zero_upper = w_zero_upper && (w_disp_next[4*k +: 4] == 4'h0);
      w_blank[k]   = w_zero_upper;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Output selection from next-state index so anode and nibble move together
  always_comb begin
    w_num_next = 4'h0;
    w_an_next  = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_next == IDX_W'(k)) begin
        w_num_next   = w_disp_next[4*k +: 4];
        w_an_next[k] = w_blank[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick    <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
      r_num     <= 4'h0;
      r_an      <= '1;
      r_frame   <= 1'b0;
    end else begin
      r_tick    <= w_tick_next;
      r_idx     <= w_idx_next;
      r_shadow  <= w_shadow_next;
      r_disp    <= w_disp_next;
      r_pending <= w_pending_next;
      r_num     <= w_num_next;
      r_an      <= w_an_next;
      r_frame   <= w_wrap;
    end
  end

  assign pending_o = r_pending;
  assign num_o     = r_num;
  assign an_o      = r_an;
  assign frame_o   = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (NUM_DIGITS=8, REFRESH_DIV=4).
// Expectations follow SEG_LEADING_ZERO_BLANK_EN when that macro is defined for the build.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned RD = 4;

  logic        clk;
  logic        rst_n;
  logic        load_i;
  logic [31:0] value_i;
  logic        pending_o;
  logic [3:0]  num_o;
  logic [7:0]  an_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_i),
    .value_i  (value_i),
    .pending_o(pending_o),
    .num_o    (num_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts rising edges since reset release; the active digit is (cyc/4)%8
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  function automatic int digit_of(input int c);
    return (c / int'(RD)) % int'(ND);
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] v, input int d);
    logic [31:0] t;
    t = v >> (4 * d);
    return t[3:0];
  endfunction

  function automatic logic [7:0] exp_an(input logic [31:0] v, input int d);
    logic [7:0] a;
    a    = 8'hFF;
    a[d] = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      logic [31:0] up;
      up = v >> (4 * d);
      if (d > 0 && up == 32'h0) a = 8'hFF;
    end
`endif
    return a;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    load_i  = 1'b0;
    value_i = 32'h0;
    repeat (5) step();
    checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", an_o); end
    checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL reset_num: got %h expected 0", num_o); end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending_o); end
    checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_o); end
    rst_n = 1'b1;
    cyc   = 0;
    step();
    checks++; if (an_o !== 8'hFE) begin errors++; $display("FAIL release_an: got %h expected fe", an_o); end
    checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL release_num: got %h expected 0", num_o); end
  endtask

  task automatic test_scan();
    logic [31:0] v;
    int d;
    v = 32'h89ABCDEF;
    run_to(5);
    load_i = 1'b1; value_i = v;
    step();
    load_i = 1'b0; value_i = 32'h0;
    checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL scan_pending_rise: got %b expected 1", pending_o); end
    run_to(31);
    checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL scan_old_num: got %h expected 0", num_o); end
    checks++; if (an_o !== exp_an(32'h0, 7)) begin errors++; $display("FAIL scan_old_an: got %h expected %h", an_o, exp_an(32'h0, 7)); end
    checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL scan_pending_hold: got %b expected 1", pending_o); end
    while (cyc < 96) begin
      step();
      d = digit_of(cyc);
      checks++; if (num_o !== nib(v, d)) begin errors++; $display("FAIL scan_num cyc=%0d: got %h expected %h", cyc, num_o, nib(v, d)); end
      checks++; if (an_o !== exp_an(v, d)) begin errors++; $display("FAIL scan_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(v, d)); end
      checks++; if (frame_o !== (cyc % 32 == 0)) begin errors++; $display("FAIL scan_frame cyc=%0d: got %b expected %b", cyc, frame_o, (cyc % 32 == 0)); end
      checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL scan_pending_clear cyc=%0d: got %b expected 0", cyc, pending_o); end
    end
  endtask

  task automatic test_tear_free();
    logic [31:0] v_old, v_new, v;
    int d;
    v_old = 32'h89ABCDEF;
    v_new = 32'h11111111;
    run_to(109);
    checks++; if (num_o !== 4'hC) begin errors++; $display("FAIL tear_pre_num: got %h expected c", num_o); end
    load_i = 1'b1; value_i = v_new;
    step();
    load_i = 1'b0; value_i = 32'h0;
    while (cyc <= 159) begin
      d = digit_of(cyc);
      v = (cyc < 128) ? v_old : v_new;
      checks++; if (num_o !== nib(v, d)) begin errors++; $display("FAIL tear_num cyc=%0d: got %h expected %h", cyc, num_o, nib(v, d)); end
      checks++; if (an_o !== exp_an(v, d)) begin errors++; $display("FAIL tear_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(v, d)); end
      checks++; if (pending_o !== (cyc < 128)) begin errors++; $display("FAIL tear_pending cyc=%0d: got %b expected %b", cyc, pending_o, (cyc < 128)); end
      step();
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    logic [7:0]  lit;
    logic [7:0]  exp_lit;
    int d;
    v   = 32'h00000042;
    lit = 8'h00;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp_lit = 8'h03;
`else
    exp_lit = 8'hFF;
`endif
    run_to(191);
    load_i = 1'b1; value_i = v;
    step();
    load_i = 1'b0; value_i = 32'h0;
    checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL simul_frame: got %b expected 1", frame_o); end
    checks++; if (num_o !== 4'h2) begin errors++; $display("FAIL simul_num: got %h expected 2", num_o); end
    checks++; if (an_o !== 8'hFE) begin errors++; $display("FAIL simul_an: got %h expected fe", an_o); end
    while (cyc <= 223) begin
      d = digit_of(cyc);
      lit = lit | ~an_o;
      checks++; if (num_o !== nib(v, d)) begin errors++; $display("FAIL simul_num cyc=%0d: got %h expected %h", cyc, num_o, nib(v, d)); end
      checks++; if (an_o !== exp_an(v, d)) begin errors++; $display("FAIL simul_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(v, d)); end
      checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL simul_pending cyc=%0d: got %b expected 0", cyc, pending_o); end
      step();
    end
    checks++; if (lit !== exp_lit) begin errors++; $display("FAIL blank_42_mask: got %h expected %h", lit, exp_lit); end
  endtask

  task automatic test_blank_zero();
    logic [7:0] lit;
    logic [7:0] exp_lit;
    int d;
    lit = 8'h00;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp_lit = 8'h01;
`else
    exp_lit = 8'hFF;
`endif
    run_to(255);
    load_i = 1'b1; value_i = 32'h0;
    step();
    load_i = 1'b0;
    while (cyc <= 287) begin
      d = digit_of(cyc);
      lit = lit | ~an_o;
      checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL zero_num cyc=%0d: got %h expected 0", cyc, num_o); end
      checks++; if (an_o !== exp_an(32'h0, d)) begin errors++; $display("FAIL zero_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(32'h0, d)); end
      step();
    end
    checks++; if (lit !== exp_lit) begin errors++; $display("FAIL blank_0_mask: got %h expected %h", lit, exp_lit); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int d;
    v = 32'h87654321;
    run_to(290);
    load_i = 1'b1; value_i = 32'h12345678;
    step();
    value_i = v;
    step();
    load_i = 1'b0; value_i = 32'h0;
    checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b expected 1", pending_o); end
    run_to(320);
    while (cyc <= 351) begin
      d = digit_of(cyc);
      checks++; if (num_o !== nib(v, d)) begin errors++; $display("FAIL b2b_num cyc=%0d: got %h expected %h", cyc, num_o, nib(v, d)); end
      checks++; if (an_o !== exp_an(v, d)) begin errors++; $display("FAIL b2b_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(v, d)); end
      step();
    end
  endtask

  task automatic test_mid_reset();
    int d;
    run_to(356);
    load_i = 1'b1; value_i = 32'hCAFE0123;
    step();
    load_i = 1'b0; value_i = 32'h0;
    checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL mrst_pending_pre: got %b expected 1", pending_o); end
    run_to(360);
    rst_n = 1'b0;
    step();
    checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL mrst_an: got %h expected ff", an_o); end
    checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL mrst_num: got %h expected 0", num_o); end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL mrst_pending: got %b expected 0", pending_o); end
    checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL mrst_frame: got %b expected 0", frame_o); end
    step();
    rst_n = 1'b1;
    cyc   = 0;
    step();
    checks++; if (an_o !== 8'hFE) begin errors++; $display("FAIL mrst_release_an: got %h expected fe", an_o); end
    checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL mrst_release_num: got %h expected 0", num_o); end
    run_to(32);
    checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL mrst_frame_pulse: got %b expected 1", frame_o); end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL mrst_no_commit: got %b expected 0", pending_o); end
    while (cyc <= 63) begin
      d = digit_of(cyc);
      checks++; if (num_o !== 4'h0) begin errors++; $display("FAIL mrst_num cyc=%0d: got %h expected 0", cyc, num_o); end
      checks++; if (an_o !== exp_an(32'h0, d)) begin errors++; $display("FAIL mrst_an cyc=%0d: got %h expected %h", cyc, an_o, exp_an(32'h0, d)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_simultaneous();
    test_blank_zero();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
